// File: rtl/lc3_io_pkg.sv
// Shared LC-3 memory-mapped I/O definitions: device addresses, DSR bit layout
// and the display transmitter state encoding.
package lc3_io_pkg;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    localparam int unsigned READY_BIT = 15;
    localparam int unsigned IE_BIT    = 14;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/lc3_baud_tick.sv
// Bit-period timer: free-runs 0..CLKS_PER_BIT-1 while enabled and pulses TICK
// on the last count of each bit; held at zero while disabled.
module lc3_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    output logic TICK
);

    if (CLKS_PER_BIT < 2) begin : g_cpb_check
        $error("lc3_baud_tick: CLKS_PER_BIT must be at least 2");
    end

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!EN || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign TICK = EN && (cnt_q == LAST);

endmodule

// File: rtl/lc3_display_tx.sv
// LC-3 display device: owns DSR/DDR, captures stores to DDR and shifts each
// accepted byte out as an 8N1 frame on TX.
module lc3_display_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [15:0] DSR_ADDR     = 16'hFE04,
    parameter logic [15:0] DDR_ADDR     = 16'hFE06
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] MAR_IN,
    input  logic [15:0] BUS_IN,
    input  logic        MIO_EN,
    input  logic        R_W,
    output logic [15:0] DSR_OUT,
    output logic [15:0] DDR_OUT,
    output logic        DSR_INT,
    output logic        TX
);

    import lc3_io_pkg::*;

    tx_state_t  state_q, state_d;
    logic       ready_q, ready_d;
    logic       ie_q, ie_d;
    logic       tx_q, tx_d;
    logic [7:0] ddr_q, ddr_d;
    logic [2:0] bit_q, bit_d;

    logic wr, ddr_acc, dsr_wr, baud_en, tick;
    logic unused_bus;

    assign wr      = MIO_EN & R_W;
    assign ddr_acc = wr && (MAR_IN == DDR_ADDR) && ready_q;
    assign dsr_wr  = wr && (MAR_IN == DSR_ADDR);
    assign baud_en = (state_q != TX_IDLE);
    assign unused_bus = ^{BUS_IN[15], BUS_IN[13:8]};

    lc3_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .CLK (CLK),
        .RST (RST),
        .EN  (baud_en),
        .TICK(tick)
    );

    // READY is high exactly while idle, so a busy DDR store never matches ddr_acc.
    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        ie_d    = ie_q;
        tx_d    = tx_q;
        ddr_d   = ddr_q;
        bit_d   = bit_q;
        if (dsr_wr) begin
            ie_d = BUS_IN[IE_BIT];
        end
        case (state_q)
            TX_IDLE: begin
                if (ddr_acc) begin
                    ddr_d   = BUS_IN[7:0];
                    ready_d = 1'b0;
                    tx_d    = 1'b0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (tick) begin
                    bit_d   = '0;
                    tx_d    = ddr_q[0];
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = ddr_q[bit_q + 3'd1];
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    ready_d = 1'b1;
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= TX_IDLE;
            ready_q <= 1'b1;
            ie_q    <= 1'b0;
            tx_q    <= 1'b1;
            ddr_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            ie_q    <= ie_d;
            tx_q    <= tx_d;
            ddr_q   <= ddr_d;
            bit_q   <= bit_d;
        end
    end

    assign DSR_OUT = {ready_q, ie_q, 14'b0};
    assign DDR_OUT = {8'h00, ddr_q};
    assign DSR_INT = ready_q & ie_q;
    assign TX      = tx_q;

endmodule

// File: tb/tb_lc3_display_tx.sv
// Directed plus randomized bench for lc3_display_tx against a frame-timing
// reference model (CLKS_PER_BIT = 4).
module tb_lc3_display_tx;

    localparam int unsigned CPB   = 4;
    localparam logic [15:0] DSR_A = 16'hFE04;
    localparam logic [15:0] DDR_A = 16'hFE06;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] MAR_IN, BUS_IN;
    logic        MIO_EN, R_W;
    logic [15:0] DSR_OUT, DDR_OUT;
    logic        DSR_INT, TX;

    int errors = 0;
    int checks = 0;

    // Reference model: a frame is just its start cycle and byte.
    logic       m_ready, m_ie, m_busy;
    logic [7:0] m_byte;
    int         cyc = 0;
    int         m_start = 0;

    logic [9:0] frame41 = 10'b1010000010;

    lc3_display_tx #(
        .CLKS_PER_BIT(CPB),
        .DSR_ADDR    (DSR_A),
        .DDR_ADDR    (DDR_A)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .MAR_IN (MAR_IN),
        .BUS_IN (BUS_IN),
        .MIO_EN (MIO_EN),
        .R_W    (R_W),
        .DSR_OUT(DSR_OUT),
        .DDR_OUT(DDR_OUT),
        .DSR_INT(DSR_INT),
        .TX     (TX)
    );

    always #5 CLK = ~CLK;

    function automatic logic exp_tx();
        int slot;
        if (!m_busy) return 1'b1;
        slot = (cyc - m_start) / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return m_byte[slot-1];
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        check("tx",      {15'b0, TX},      {15'b0, exp_tx()});
        check("dsr_out", DSR_OUT,          {m_ready, m_ie, 14'b0});
        check("ddr_out", DDR_OUT,          {8'h00, m_byte});
        check("dsr_int", {15'b0, DSR_INT}, {15'b0, m_ready & m_ie});
    endtask

    task automatic step(input logic mio, input logic rw, input logic [15:0] mar, input logic [15:0] bus);
        logic wr, fin, acc;
        MIO_EN = mio;
        R_W    = rw;
        MAR_IN = mar;
        BUS_IN = bus;
        @(posedge CLK);
        cyc++;
        wr  = mio & rw;
        fin = m_busy && ((cyc - m_start) == 10 * CPB);
        acc = wr && (mar == DDR_A) && m_ready;
        if (wr && mar == DSR_A) m_ie = bus[14];
        if (fin) begin
            m_ready = 1'b1;
            m_busy  = 1'b0;
        end
        if (acc) begin
            m_ready = 1'b0;
            m_busy  = 1'b1;
            m_start = cyc;
            m_byte  = bus[7:0];
        end
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic store(input logic [15:0] mar, input logic [15:0] bus);
        step(1'b1, 1'b1, mar, bus);
    endtask

    // Called 1 time unit after a rising edge; RST rises mid-cycle.
    task automatic do_reset();
        #2 RST = 1'b1;
        #1;
        m_ready = 1'b1;
        m_ie    = 1'b0;
        m_byte  = 8'h00;
        m_busy  = 1'b0;
        check_all();
        check("rst_dsr", DSR_OUT, 16'h8000);
        check("rst_tx",  {15'b0, TX}, 16'h0001);
        @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    initial begin
        int r;
        RST = 1'b0; MIO_EN = 1'b0; R_W = 1'b0; MAR_IN = '0; BUS_IN = '0;
        m_ready = 1'b1; m_ie = 1'b0; m_busy = 1'b0; m_byte = 8'h00;
        @(posedge CLK);
        #1;
        do_reset();
        idle(3);

        // Single frame of 8'h41 against a fixed bit table
        store(DDR_A, 16'h0041);
        check("frame_bit", {15'b0, TX}, {15'b0, frame41[0]});
        check("busy_dsr", DSR_OUT, 16'h0000);
        for (int k = 1; k < 40; k++) begin
            idle(1);
            if (k % CPB == 2) check("frame_bit", {15'b0, TX}, {15'b0, frame41[k / CPB]});
        end
        check("pre_ready", DSR_OUT, 16'h0000);
        idle(1);
        check("ready_40", DSR_OUT, 16'h8000);
        check("ddr_hold", DDR_OUT, 16'h0041);
        idle(4);

        // Busy write rejection
        store(DDR_A, 16'h0041);
        idle(9);
        store(DDR_A, 16'h005A);
        check("busy_ddr", DDR_OUT, 16'h0041);
        idle(30);
        idle(10);
        check("no_second", {15'b0, TX}, 16'h0001);

        // Boundary write on the edge READY rises
        store(DDR_A, 16'h0041);
        idle(39);
        store(DDR_A, 16'h005A);
        check("bound_ign", DDR_OUT, 16'h0041);
        check("bound_tx", {15'b0, TX}, 16'h0001);
        store(DDR_A, 16'h005A);
        check("bound_acc", DDR_OUT, 16'h005A);
        idle(42);

        // Interrupt enable during a frame
        store(DDR_A, 16'h0033);
        idle(5);
        store(DSR_A, 16'h4000);
        check("ie_busy", DSR_OUT, 16'h4000);
        idle(33);
        check("int_low", {15'b0, DSR_INT}, 16'h0000);
        idle(1);
        check("int_high", {15'b0, DSR_INT}, 16'h0001);
        check("int_dsr", DSR_OUT, 16'hC000);
        store(DSR_A, 16'h0000);
        check("int_clr", DSR_OUT, 16'h8000);
        idle(3);

        // Reset during data bit 3, then a clean frame
        store(DSR_A, 16'h4000);
        store(DDR_A, 16'h0096);
        idle(17);
        do_reset();
        store(DDR_A, 16'h00FF);
        idle(40);
        check("post_rst_ddr", DDR_OUT, 16'h00FF);
        check("post_rst_dsr", DSR_OUT, 16'h8000);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1: store(DDR_A, 16'($urandom));
                2:    store(DSR_A, 16'($urandom));
                3:    step(1'b1, 1'b0, DDR_A, 16'($urandom));
                4:    step(1'b1, 1'b0, DSR_A, 16'($urandom));
                5:    store(16'hFE02, 16'($urandom));
                6:    step(1'b0, 1'b1, DDR_A, 16'($urandom));
                default: idle(1);
            endcase
        end
        idle(45);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lc3_display_tx.md
Name: lc3_display_tx

Overview:
- Memory-mapped display output device for the LC-3 datapath. It is the write-side counterpart of the input multiplexer that returns KBDR/KBSR/DSR/MEM data onto the bus.
- It owns the DSR (xFE04) and DDR (xFE06) registers and captures bus stores to DDR.
- Each accepted DDR byte is serialised onto a UART-style TX line: 1 start bit, 8 data bits LSB first, 1 stop bit.
- DSR_OUT feeds the DSR_OUT input of the input multiplexer.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit. Legal values are 2 and above; other values are a compile-time error.
- DSR_ADDR, 16'hFE04, address of the display status register.
- DDR_ADDR, 16'hFE06, address of the display data register.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge
- RST  in  1  asynchronous, active-high reset
- MAR_IN  in  16  current MAR value (device address)
- BUS_IN  in  16  bus data for stores
- MIO_EN  in  1  memory/IO access cycle enable
- R_W  in  1  1 = write (store), 0 = read
- DSR_OUT  out  16  {READY, IE, 14'b0}
- DDR_OUT  out  16  {8'h00, last accepted byte}
- DSR_INT  out  1  interrupt request, equal to READY & IE
- TX  out  1  serial line; idle high

Behaviour:
- Reset (asynchronous, on RST high):
  - READY=1, IE=0, DDR byte=8'h00.
  - State=IDLE, TX=1, baud counter=0, bit index=0.
  - Therefore DSR_OUT=16'h8000, DDR_OUT=16'h0000, DSR_INT=0.
  - Reset mid-frame aborts the frame; TX returns high immediately.
- Write decode (all sampled on the rising edge):
  - wr = MIO_EN & R_W.
  - DDR write: wr & MAR_IN==DDR_ADDR & READY=1.
    - Latches BUS_IN[7:0] into DDR.
    - Clears READY.
    - Moves state IDLE->START.
  - DDR write while READY=0: ignored. The DDR value and the frame in progress are unchanged.
  - DSR write: wr & MAR_IN==DSR_ADDR.
    - Sets IE=BUS_IN[14].
    - READY is read-only; BUS_IN[15] is ignored.
  - Reads (R_W=0) have no side effects.
  - Writes to any other address are ignored.
- State machine: IDLE, START, DATA, STOP. TX is driven from registered state, so it is glitch-free.
  - IDLE: TX=1. Leaves only on an accepted DDR write.
  - START: TX=0 for CLKS_PER_BIT cycles, then goes to DATA with bit index=0.
  - DATA: TX=DDR[bit index] for CLKS_PER_BIT cycles per bit.
    - The bit index increments 0..7.
    - After bit 7 completes, goes to STOP.
  - STOP: TX=1 for CLKS_PER_BIT cycles, then goes to IDLE and sets READY=1 on the same edge.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Held at 0 in IDLE.
  - Width is $clog2(CLKS_PER_BIT).
- Latency:
  - Accepted write on edge E0: TX is low from E0 onward (same cycle as READY falling).
  - Data bit k occupies edges E0+(k+1)*CPB to E0+(k+2)*CPB.
  - READY rises on edge E0+10*CPB.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- Simultaneous events:
  - DDR write on the same edge the STOP bit finishes: READY is still 0 at that edge, so the write is ignored. Software must poll DSR.
  - DSR write during a frame updates IE without disturbing the frame.
  - With IE set and READY rising, DSR_INT asserts on the same edge as READY.
- DDR_OUT holds its value after the frame finishes, until the next accepted write.

Decomposition:
- Shared package lc3_io_pkg holds:
  - localparams KBSR_ADDR=16'hFE00, KBDR_ADDR=16'hFE02, DSR_ADDR=16'hFE04, DDR_ADDR=16'hFE06.
  - typedef enum logic [1:0] tx_state_t {TX_IDLE, TX_START, TX_DATA, TX_STOP}.
  - DSR bit-position constants READY_BIT=15, IE_BIT=14.
- One sub-module, lc3_baud_tick:
  - Parameter CLKS_PER_BIT.
  - Inputs CLK, RST, EN.
  - Output TICK, a one-cycle pulse when the count reaches CLKS_PER_BIT-1; the counter clears when EN=0.
  - The top FSM advances only on TICK.

Test Plan:
- Reset check (CPB=4): assert RST asynchronously mid-cycle -> DSR_OUT=16'h8000, DDR_OUT=16'h0000, TX=1, DSR_INT=0 immediately, with no clock edge needed.
- Single frame (CPB=4): store x0041 to xFE06 -> TX sequence 0,1,0,0,0,0,0,1,0,1 (start, LSB-first 8'h41, stop), each bit 4 cycles. DSR_OUT=16'h0000 during the frame; it returns to 16'h8000 exactly 40 cycles after the write edge; DDR_OUT=16'h0041.
- Busy write rejection: store x0041, then store x005A to xFE06 at cycle 10 -> the frame is still 8'h41, DDR_OUT stays 16'h0041, and no second frame follows.
- Boundary write: store x005A on the exact edge READY rises -> ignored, TX stays 1. A repeat one cycle later -> accepted, and a frame for 8'h5A is sent.
- Interrupt: store x4000 to xFE04 during a frame -> DSR_INT=0 until READY rises, then DSR_INT=1 with DSR_OUT=16'hC000. Store x0000 to xFE04 -> DSR_INT=0 and READY unaffected.
- Reset mid-frame: assert RST at data bit 3 -> TX=1 at once, READY=1. A subsequent store of x00FF produces a clean full frame.
